apb_slave_array: RTL and testbench
==================================

APB_SLAVE_ARRAY -- requirements
Module: apb_slave_array

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, Paddr width.
REQ-002 SHALL have parameter DATA_W, default 32, Pwdata/Prdata width.
REQ-003 SHALL have parameter NUM_SEL, default 3, number of APB completers (one Pselx bit each).
REQ-004 SHALL have parameter DEPTH, default 16, words per completer (power of two, >=2).
REQ-005 SHALL have parameter WAIT_CYC, default 0, wait states inserted per access (0..15).
REQ-006 Hclk  input  1  single clock; all state changes on rising edge.
REQ-007 Hreset  input  1  synchronous, active-high reset.
REQ-008 Pselx  input  NUM_SEL  one-hot completer select.
REQ-009 Penable  input  1  APB access-phase strobe.
REQ-010 Pwrite  input  1  1 = write, 0 = read.
REQ-011 Paddr  input  ADDR_W  byte address.
REQ-012 Pwdata  input  DATA_W  write data.
REQ-013 Prdata  output  DATA_W  registered read data.
REQ-014 Pready  output  1  transfer-complete, registered.
REQ-015 Pslverr  output  1  transfer error, registered; meaningful only while Pready=1.

Function
REQ-016 SHALL implement FSM ST_IDLE, ST_ACCESS, ST_DONE.
REQ-017 ST_IDLE: on Pselx!=0 and Penable=0 (setup phase) SHALL go to ST_ACCESS, latch Paddr/Pwrite/Pwdata/Pselx, load wait counter with WAIT_CYC.
REQ-018 ST_ACCESS: while counter!=0 SHALL decrement once per cycle with Pready=0; when counter==0 SHALL assert Pready=1 for exactly one cycle.
REQ-019 Zero-wait (WAIT_CYC=0): Pready SHALL be 1 in the first Penable=1 cycle, i.e. 2-cycle transfer; N waits -> 2+N cycles.
REQ-020 Write SHALL commit on the edge ending the Pready=1 cycle, only if Pslverr=0.
REQ-021 Read data SHALL be presented on Prdata in the Pready=1 cycle; Prdata SHALL hold its last value otherwise.
REQ-022 Word index = Paddr[log2(DEPTH)+1:2]; bank = position of the set Pselx bit.
REQ-023 Pslverr=1 (no write, Prdata=0) SHALL result from: Paddr[1:0]!=0, Paddr >= DEPTH*4, or more than one Pselx bit set.
REQ-024 After Pready=1 the FSM SHALL go to ST_DONE for one cycle, then ST_IDLE; a new setup phase in ST_DONE SHALL be accepted (back-to-back transfers).
REQ-025 Penable=1 seen in ST_IDLE without a prior setup phase SHALL be ignored (no state change, no access).
REQ-026 Pselx dropping to 0 during ST_ACCESS SHALL abort to ST_IDLE with Pready=0 and no write.

Reset
REQ-027 Hreset=1 SHALL force ST_IDLE, counter=0, Prdata=0, Pready=0, Pslverr=0 on the next edge.
REQ-028 All storage words SHALL reset to 0.
REQ-029 Reset asserted mid-transfer SHALL abort it; the pending write SHALL NOT commit.

Structure
REQ-030 State encoding, error-cause constants and the clog2 helper SHALL live in shared package apb_pkg.
REQ-031 Storage SHALL be one sub-module apb_reg_bank (DEPTH x DATA_W, sync write, async read), instantiated NUM_SEL times.

Verification
REQ-032 Write 0xDEADBEEF to bank 0 addr 0x04, WAIT_CYC=0, then read -> Pready on 2nd cycle each, Prdata=0xDEADBEEF, Pslverr=0.
REQ-033 WAIT_CYC=3, read bank 2 addr 0x3C -> Pready low 3 access cycles, high on 4th, transfer 5 cycles total.
REQ-034 Write Paddr=0x40 (DEPTH=16) and Paddr=0x06 -> Pslverr=1 with Pready, storage unchanged on readback.
REQ-035 Pselx=3'b011 write -> Pslverr=1, neither bank 0 nor bank 1 modified.
REQ-036 Hreset pulsed during ST_ACCESS of write 0x12345678 to bank 1 addr 0x08 -> Pready stays 0, readback returns 0.
REQ-037 Back-to-back write/read to banks 0 and 1 with setup issued in ST_DONE -> both complete, no lost transfer, correct data.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared FSM encoding, error-cause indices and sizing helper for
//             the APB completer array.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } apb_state_t;

    // Bit positions inside the error-cause vector
    localparam int c_err_align = 0;
    localparam int c_err_range = 1;
    localparam int c_err_multi = 2;
    localparam int c_err_w     = 3;

    localparam int c_cnt_w = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : apb_reg_bank
//  Purpose  : DEPTH x DATA_W word store, synchronous write, asynchronous read.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/apb_slave_array.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_array
//  Purpose  : NUM_SEL APB completers sharing one FSM, each backed by a word
//             store, with programmable wait states and error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_array
    import apb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_SEL  = 3,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic [NUM_SEL-1:0] Pselx,
    input  logic               Penable,
    input  logic               Pwrite,
    input  logic [ADDR_W-1:0]  Paddr,
    input  logic [DATA_W-1:0]  Pwdata,
    output logic [DATA_W-1:0]  Prdata,
    output logic               Pready,
    output logic               Pslverr
);

    localparam int                 c_idx_w    = clog2(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WAIT_CYC);

    apb_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_write, w_write_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_SEL-1:0]  r_sel, w_sel_nxt;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_pready, r_pslverr;
    logic                w_setup, w_accept, w_pready_nxt, w_err, w_we;
    logic [c_err_w-1:0]  w_err_cause;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_bank_rdata [NUM_SEL];

    assign w_setup = (|Pselx) & ~Penable;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (w_setup) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            ST_ACCESS: begin
                if (Pselx == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered, so decode the transfer as it will look next cycle
    assign w_addr_nxt  = w_accept ? Paddr  : r_addr;
    assign w_write_nxt = w_accept ? Pwrite : r_write;
    assign w_sel_nxt   = w_accept ? Pselx  : r_sel;

    assign w_err_cause[c_err_align] = |w_addr_nxt[1:0];
    assign w_err_cause[c_err_range] = |w_addr_nxt[ADDR_W-1:c_idx_w+2];
    assign w_err_cause[c_err_multi] = $countones(w_sel_nxt) > 1;
    assign w_err                    = |w_err_cause;

    assign w_pready_nxt = (w_state_nxt == ST_ACCESS) && (w_cnt_nxt == '0);

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (w_sel_nxt[i]) w_rdata = w_rdata | w_bank_rdata[i];
        end
    end

    // Commit on the edge that closes the Pready cycle, unless errored or aborted
    assign w_we = (r_state == ST_ACCESS) && r_pready && !r_pslverr && r_write && (|Pselx);

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pready_nxt & w_err;
            if (w_accept) begin
                r_addr  <= Paddr;
                r_write <= Pwrite;
                r_wdata <= Pwdata;
                r_sel   <= Pselx;
            end
            if (w_pready_nxt) begin
                if (w_err)             r_prdata <= '0;
                else if (!w_write_nxt) r_prdata <= w_rdata;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_SEL; g++) begin : g_bank
            apb_reg_bank #(
                .DEPTH  (DEPTH),
                .DATA_W (DATA_W),
                .IDX_W  (c_idx_w)
            ) u_bank (
                .clk     (Hclk),
                .rst     (Hreset),
                .i_we    (w_we & r_sel[g]),
                .i_waddr (r_addr[c_idx_w+1:2]),
                .i_wdata (r_wdata),
                .i_raddr (w_addr_nxt[c_idx_w+1:2]),
                .o_rdata (w_bank_rdata[g])
            );
        end
    endgenerate

    assign Prdata  = r_prdata;
    assign Pready  = r_pready;
    assign Pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_slave_array
//  Purpose  : Directed bench for apb_slave_array, zero-wait and 3-wait builds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  r_psel = '0;
    logic        r_penable = 1'b0;
    logic        r_pwrite = 1'b0;
    logic [31:0] r_paddr = '0;
    logic [31:0] r_pwdata = '0;
    logic        r_use3 = 1'b0;

    logic [31:0] w_prdata0, w_prdata3, w_prdata;
    logic        w_pready0, w_pready3, w_pready;
    logic        w_pslverr0, w_pslverr3, w_pslverr;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] rd;
    int          acc;
    logic        err;

    always #5 clk = ~clk;

    apb_slave_array #(
        .ADDR_W(32), .DATA_W(32), .NUM_SEL(3), .DEPTH(16), .WAIT_CYC(0)
    ) u_dut0 (
        .Hclk(clk), .Hreset(rst), .Pselx(r_psel), .Penable(r_penable),
        .Pwrite(r_pwrite), .Paddr(r_paddr), .Pwdata(r_pwdata),
        .Prdata(w_prdata0), .Pready(w_pready0), .Pslverr(w_pslverr0)
    );

    apb_slave_array #(
        .ADDR_W(32), .DATA_W(32), .NUM_SEL(3), .DEPTH(16), .WAIT_CYC(3)
    ) u_dut3 (
        .Hclk(clk), .Hreset(rst), .Pselx(r_psel), .Penable(r_penable),
        .Pwrite(r_pwrite), .Paddr(r_paddr), .Pwdata(r_pwdata),
        .Prdata(w_prdata3), .Pready(w_pready3), .Pslverr(w_pslverr3)
    );

    assign w_prdata  = r_use3 ? w_prdata3  : w_prdata0;
    assign w_pready  = r_use3 ? w_pready3  : w_pready0;
    assign w_pslverr = r_use3 ? w_pslverr3 : w_pslverr0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer; starts and returns just after a rising edge
    task automatic xfer(input logic [2:0] sel, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic b2b,
                        output logic [31:0] rdata, output int cycles, output logic slverr);
        int  n;
        bit  done;
        r_psel = sel; r_paddr = addr; r_pwrite = wr; r_pwdata = wdata; r_penable = 1'b0;
        @(posedge clk); #1 r_penable = 1'b1;
        n = 0; done = 1'b0; rdata = '0; slverr = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (w_pready) begin
                done = 1'b1; rdata = w_prdata; slverr = w_pslverr;
            end
            @(posedge clk); #1;
        end
        chk("xfer_completed", 32'(done), 32'd1);
        cycles = n;
        r_penable = 1'b0;
        if (!b2b) begin
            r_psel = '0; r_pwrite = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready0",  32'(w_pready0),  32'd0);
        chk("rst_pslverr0", 32'(w_pslverr0), 32'd0);
        chk("rst_prdata0",  w_prdata0,       32'd0);
        chk("rst_pready3",  32'(w_pready3),  32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait write then read
        xfer(3'b001, 32'h04, 1'b1, 32'hDEADBEEF, 1'b0, rd, acc, err);
        chk("wr0_cycles", 32'(acc), 32'd1);
        chk("wr0_slverr", 32'(err), 32'd0);
        xfer(3'b001, 32'h04, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("rd0_cycles", 32'(acc), 32'd1);
        chk("rd0_data",   rd,       32'hDEADBEEF);
        chk("rd0_slverr", 32'(err), 32'd0);

        // Penable without a setup phase is ignored
        r_psel = 3'b001; r_paddr = 32'h04; r_penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("orphan_enable_pready", 32'(w_pready0), 32'd0);
        end
        @(posedge clk); #1 r_psel = '0; r_penable = 1'b0;
        @(posedge clk); #1;

        // Address errors leave storage untouched
        xfer(3'b001, 32'h00, 1'b1, 32'hA5A5A5A5, 1'b0, rd, acc, err);
        chk("wr_a5_slverr", 32'(err), 32'd0);
        xfer(3'b001, 32'h40, 1'b1, 32'hBAD0BAD0, 1'b0, rd, acc, err);
        chk("wr_range_slverr", 32'(err), 32'd1);
        xfer(3'b001, 32'h06, 1'b1, 32'h0BADF00D, 1'b0, rd, acc, err);
        chk("wr_align_slverr", 32'(err), 32'd1);
        xfer(3'b001, 32'h00, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("rb_addr00", rd, 32'hA5A5A5A5);
        xfer(3'b001, 32'h04, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("rb_addr04", rd, 32'hDEADBEEF);
        xfer(3'b001, 32'h06, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("rd_align_slverr", 32'(err), 32'd1);
        chk("rd_align_data",   rd,       32'd0);

        // Multi-select write is rejected
        xfer(3'b011, 32'h08, 1'b1, 32'hCAFEF00D, 1'b0, rd, acc, err);
        chk("multi_slverr", 32'(err), 32'd1);
        xfer(3'b001, 32'h08, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("multi_bank0", rd, 32'd0);
        xfer(3'b010, 32'h08, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("multi_bank1", rd, 32'd0);

        // Three wait states
        r_use3 = 1'b1;
        xfer(3'b100, 32'h3C, 1'b1, 32'h5A5A0003, 1'b0, rd, acc, err);
        chk("w3_wr_cycles", 32'(acc), 32'd4);
        xfer(3'b100, 32'h3C, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("w3_rd_cycles", 32'(acc), 32'd4);
        chk("w3_rd_data",   rd,       32'h5A5A0003);
        chk("w3_rd_slverr", 32'(err), 32'd0);

        // Deselect mid-access aborts without writing
        r_psel = 3'b100; r_paddr = 32'h20; r_pwrite = 1'b1; r_pwdata = 32'h77777777; r_penable = 1'b0;
        @(posedge clk); #1 r_penable = 1'b1;
        @(negedge clk);
        chk("abort_pready_a", 32'(w_pready3), 32'd0);
        @(posedge clk); #1 r_psel = '0; r_penable = 1'b0; r_pwrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_pready_b", 32'(w_pready3), 32'd0);
        end
        @(posedge clk); #1;
        xfer(3'b100, 32'h20, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("abort_readback", rd, 32'd0);

        // Reset during the access phase of a write
        r_psel = 3'b010; r_paddr = 32'h08; r_pwrite = 1'b1; r_pwdata = 32'h12345678; r_penable = 1'b0;
        @(posedge clk); #1 r_penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pready_a", 32'(w_pready3), 32'd0);
        @(posedge clk); #1 rst = 1'b0; r_psel = '0; r_penable = 1'b0; r_pwrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_pready_b", 32'(w_pready3), 32'd0);
        end
        chk("rst_mid_prdata", w_prdata3, 32'd0);
        @(posedge clk); #1;
        xfer(3'b010, 32'h08, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("rst_mid_readback", rd, 32'd0);

        // Back-to-back transfers, each setup issued in the done cycle
        r_use3 = 1'b0;
        xfer(3'b001, 32'h10, 1'b1, 32'h11111111, 1'b1, rd, acc, err);
        chk("b2b_wr0_cycles", 32'(acc), 32'd1);
        xfer(3'b010, 32'h14, 1'b1, 32'h22222222, 1'b1, rd, acc, err);
        chk("b2b_wr1_cycles", 32'(acc), 32'd1);
        xfer(3'b001, 32'h10, 1'b0, 32'h0, 1'b1, rd, acc, err);
        chk("b2b_rd0_cycles", 32'(acc), 32'd1);
        chk("b2b_rd0_data",   rd,       32'h11111111);
        xfer(3'b010, 32'h14, 1'b0, 32'h0, 1'b0, rd, acc, err);
        chk("b2b_rd1_cycles", 32'(acc), 32'd1);
        chk("b2b_rd1_data",   rd,       32'h22222222);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
